// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU instruction/data request ports plus the shared memory port.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_read;
  logic [ADDR_W-1:0]     inst_addr;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_resp;

  logic                  data_read;
  logic                  data_write;
  logic [DATA_W/8-1:0]   data_mbe;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    input  mem_rdata, mem_resp,
    output inst_rdata, inst_resp, data_rdata, data_resp,
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    output mem_rdata, mem_resp,
    input  inst_rdata, inst_resp, data_rdata, data_resp,
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU instruction-fetch and data load/store requests onto one memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_data_req;
  logic                w_inst_req;
  logic                w_data_wins;
  logic                w_grant_data;
  logic                w_grant_inst;

  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [MBE_W-1:0]    r_mbe;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_inst_resp;
  logic                r_data_resp;

  assign w_data_req = bus.data_read | bus.data_write;
  assign w_inst_req = bus.inst_read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_data;

  // Resets to "last was INST" so data wins the first tie.
  assign w_data_wins = ~r_last_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_data <= 1'b0;
    end else if (w_grant_data | w_grant_inst) begin
      r_last_data <= w_grant_data;
    end
  end
`else
  assign w_data_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_data_req && (!w_inst_req || w_data_wins)) begin
          w_grant_data = 1'b1;
          w_state_next = DATA;
        end else if (w_inst_req) begin
          w_grant_inst = 1'b1;
          w_state_next = INST;
        end
      end
      INST, DATA: begin
        if (bus.mem_resp) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request registers and all outputs; mem_* only ever reflect what was latched at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_mbe        <= '0;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_resp  <= 1'b0;
      r_data_resp  <= 1'b0;
    end else begin
      r_inst_resp <= 1'b0;
      r_data_resp <= 1'b0;
      if (w_grant_data) begin
        r_is_write  <= bus.data_write;
        r_addr      <= bus.data_addr;
        r_mbe       <= bus.data_mbe;
        r_wdata     <= bus.data_wdata;
        r_mem_read  <= ~bus.data_write;
        r_mem_write <= bus.data_write;
      end else if (w_grant_inst) begin
        r_is_write  <= 1'b0;
        r_addr      <= bus.inst_addr;
        r_mbe       <= '1;
        r_wdata     <= '0;
        r_mem_read  <= 1'b1;
        r_mem_write <= 1'b0;
      end else if ((r_state == INST || r_state == DATA) && bus.mem_resp) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_state == DATA) begin
          r_data_resp <= 1'b1;
          if (!r_is_write) r_data_rdata <= bus.mem_rdata;
        end else begin
          r_inst_resp  <= 1'b1;
          r_inst_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_mbe    = r_mbe;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.inst_rdata = r_inst_rdata;
  assign bus.inst_resp  = r_inst_resp;
  assign bus.data_rdata = r_data_rdata;
  assign bus.data_resp  = r_data_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int errs  = 0;

  // Reference model: one transaction in flight, or a one-cycle response slot.
  bit            m_busy, m_done, m_data, m_write, m_last_data;
  logic          e_mem_read, e_mem_write, e_inst_resp, e_data_resp;
  logic [BW-1:0] e_mbe;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_inst_rdata, e_data_rdata;

  // Memory responder state; fd_lat >= 0 forces latency and read data.
  bit            r_active;
  int            r_wait;
  int            fd_lat = -1;
  logic [DW-1:0] fd_rdata = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_data = 0; m_write = 0; m_last_data = 0;
    e_mem_read = 0; e_mem_write = 0; e_inst_resp = 0; e_data_resp = 0;
    e_mbe = '0; e_addr = '0; e_wdata = '0; e_inst_rdata = '0; e_data_rdata = '0;
  endtask

  task automatic model_step();
    bit dreq, ireq, pick_data, tie_to_data;
    logic n_ir, n_dr;
    n_ir = 0;
    n_dr = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (bus.mem_resp) begin
        if (!m_write) begin
          if (m_data) e_data_rdata = bus.mem_rdata;
          else        e_inst_rdata = bus.mem_rdata;
        end
        if (m_data) n_dr = 1; else n_ir = 1;
        e_mem_read = 0; e_mem_write = 0;
        m_busy = 0; m_done = 1;
      end
    end else begin
      dreq = bus.data_read | bus.data_write;
      ireq = bus.inst_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      tie_to_data = !m_last_data;
`else
      tie_to_data = 1;
`endif
      if (dreq || ireq) begin
        pick_data = dreq && (!ireq || tie_to_data);
        m_busy = 1; m_data = pick_data; m_last_data = pick_data;
        if (pick_data) begin
          m_write = bus.data_write;
          e_addr = bus.data_addr; e_mbe = bus.data_mbe; e_wdata = bus.data_wdata;
        end else begin
          m_write = 0;
          e_addr = bus.inst_addr; e_mbe = '1;
        end
        e_mem_read = !m_write; e_mem_write = m_write;
      end
    end
    e_inst_resp = n_ir;
    e_data_resp = n_dr;
  endtask

  task automatic mem_responder();
    if (!(bus.mem_read || bus.mem_write)) begin
      bus.mem_resp = 0;
      r_active = 0;
    end else begin
      if (!r_active) begin
        r_active = 1;
        r_wait = (fd_lat >= 0) ? fd_lat : int'($urandom_range(0, 3));
      end
      if (r_wait == 0) begin
        bus.mem_resp  = 1;
        bus.mem_rdata = (fd_lat >= 0) ? fd_rdata : DW'($urandom);
      end else begin
        bus.mem_resp = 0;
        r_wait--;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_read",   DW'(bus.mem_read),   DW'(e_mem_read));
    chk("mem_write",  DW'(bus.mem_write),  DW'(e_mem_write));
    if (e_mem_read || e_mem_write) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_mbe",  DW'(bus.mem_mbe), DW'(e_mbe));
    end
    if (e_mem_write) chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("inst_resp",  DW'(bus.inst_resp),  DW'(e_inst_resp));
    chk("data_resp",  DW'(bus.data_resp),  DW'(e_data_resp));
    chk("inst_rdata", bus.inst_rdata, e_inst_rdata);
    chk("data_rdata", bus.data_rdata, e_data_rdata);
    chk("rw_exclusive",   DW'(bus.mem_read & bus.mem_write), '0);
    chk("resp_exclusive", DW'(bus.inst_resp & bus.data_resp), '0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    mem_responder();
  endtask

  task automatic clear_inputs();
    bus.inst_read = 0; bus.inst_addr = '0;
    bus.data_read = 0; bus.data_write = 0; bus.data_mbe = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;
    r_active = 0; fd_lat = -1;
  endtask

  initial begin
    bit            got_data [4];
    bit            exp_data [4];
    int            n_resp, n_ir, n_dr, resp_tick;
    bit            first;

    clear_inputs();
    model_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read",   DW'(bus.mem_read), '0);
    chk("rst_mem_write",  DW'(bus.mem_write), '0);
    chk("rst_mem_addr",   bus.mem_addr, '0);
    chk("rst_mem_mbe",    DW'(bus.mem_mbe), '0);
    chk("rst_mem_wdata",  bus.mem_wdata, '0);
    chk("rst_inst_resp",  DW'(bus.inst_resp), '0);
    chk("rst_data_resp",  DW'(bus.data_resp), '0);
    chk("rst_inst_rdata", bus.inst_rdata, '0);
    chk("rst_data_rdata", bus.data_rdata, '0);
    rst = 1;

    // Tie with both requests held continuously: order of service
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_data = '{1, 0, 1, 0};
`else
    exp_data = '{1, 1, 1, 1};
`endif
    bus.inst_read = 1; bus.inst_addr = 32'h10;
    bus.data_read = 1; bus.data_addr = 32'h20; bus.data_mbe = 4'hF;
    n_resp = 0;
    for (int c = 0; c < 40 && n_resp < 4; c++) begin
      tick();
      if (bus.inst_resp || bus.data_resp) begin
        got_data[n_resp] = bus.data_resp;
        n_resp++;
      end
    end
    chk("tie_count", DW'(n_resp), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < n_resp) chk($sformatf("tie_order_%0d", i), DW'(got_data[i]), DW'(exp_data[i]));
    clear_inputs();
    repeat (3) tick();

    // Fetch only, memory answers 2 cycles after mem_read rises
    bus.inst_read = 1; bus.inst_addr = 32'h60;
    fd_lat = 2; fd_rdata = 32'h00A00093;
    n_ir = 0; n_dr = 0; resp_tick = 0; first = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.mem_read && first) begin
        first = 0;
        chk("fetch_mem_addr", bus.mem_addr, 32'h60);
        chk("fetch_mem_mbe",  DW'(bus.mem_mbe), 32'hF);
        chk("fetch_grant_cycle", DW'(c), 32'd1);
      end
      if (bus.inst_resp) begin
        n_ir++; resp_tick = c;
        chk("fetch_rdata", bus.inst_rdata, 32'h00A00093);
        bus.inst_read = 0;
      end
      if (bus.data_resp) n_dr++;
    end
    chk("fetch_resp_count", DW'(n_ir), 32'd1);
    chk("fetch_resp_cycle", DW'(resp_tick), 32'd4);
    chk("fetch_no_data_resp", DW'(n_dr), 32'd0);
    chk("fetch_rdata_held", bus.inst_rdata, 32'h00A00093);
    fd_lat = -1;

    // Load with minimum latency, giving data_rdata a known value
    bus.data_read = 1; bus.data_addr = 32'h80; bus.data_mbe = 4'hF;
    fd_lat = 0; fd_rdata = 32'h12345678;
    resp_tick = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.data_resp) begin
        resp_tick = c;
        chk("load_rdata", bus.data_rdata, 32'h12345678);
        bus.data_read = 0;
      end
    end
    chk("load_min_round_trip", DW'(resp_tick), 32'd2);

    // Store; inputs change right after the grant and must be ignored
    bus.data_write = 1; bus.data_addr = 32'h100; bus.data_mbe = 4'b0011;
    bus.data_wdata = 32'hDEADBEEF;
    fd_lat = 3; fd_rdata = 32'hCAFEF00D;
    resp_tick = 0; first = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.mem_write) begin
        chk("store_addr_held",  bus.mem_addr, 32'h100);
        chk("store_mbe_held",   DW'(bus.mem_mbe), 32'h3);
        chk("store_wdata_held", bus.mem_wdata, 32'hDEADBEEF);
        if (first) begin
          first = 0;
          bus.data_addr = 32'h200; bus.data_mbe = 4'hF; bus.data_wdata = 32'h0;
        end
      end
      if (bus.data_resp) begin
        resp_tick = c;
        bus.data_write = 0;
      end
    end
    chk("store_resp_cycle", DW'(resp_tick), 32'd5);
    chk("store_rdata_unchanged", bus.data_rdata, 32'h12345678);
    fd_lat = -1;

    // Reset while a load is outstanding in DATA
    bus.data_read = 1; bus.data_addr = 32'h40; bus.data_mbe = 4'hF;
    fd_lat = 10; fd_rdata = 32'h1;
    repeat (3) tick();
    chk("pre_rst_mem_read", DW'(bus.mem_read), 32'd1);
    #2 rst = 0;
    #1;
    chk("async_rst_mem_read",  DW'(bus.mem_read), '0);
    chk("async_rst_mem_write", DW'(bus.mem_write), '0);
    chk("async_rst_inst_resp", DW'(bus.inst_resp), '0);
    chk("async_rst_data_resp", DW'(bus.data_resp), '0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1;
    bus.inst_read = 1; bus.inst_addr = 32'h44;
    n_ir = 0; n_dr = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.inst_resp) begin n_ir++; bus.inst_read = 0; end
      if (bus.data_resp) n_dr++;
    end
    chk("post_rst_fetch_resp", DW'(n_ir), 32'd1);
    chk("post_rst_no_data_resp", DW'(n_dr), 32'd0);

    // Randomized traffic, including mid-transaction drops and input churn
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.inst_resp) bus.inst_read = 0;
      else if (bus.inst_read) begin
        if ($urandom_range(0, 19) == 0) bus.inst_read = 0;
      end else if ($urandom_range(0, 3) == 0) bus.inst_read = 1;
      if ($urandom_range(0, 2) == 0) bus.inst_addr = $urandom;

      if (bus.data_resp) begin
        bus.data_read = 0; bus.data_write = 0;
      end else if (bus.data_read || bus.data_write) begin
        if ($urandom_range(0, 19) == 0) begin bus.data_read = 0; bus.data_write = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin bus.data_read = 1; bus.data_write = 0; end
          1:       begin bus.data_read = 0; bus.data_write = 1; end
          default: begin bus.data_read = 1; bus.data_write = 1; end
        endcase
      end
      if ($urandom_range(0, 2) == 0) bus.data_addr  = $urandom;
      if ($urandom_range(0, 2) == 0) bus.data_wdata = $urandom;
      if ($urandom_range(0, 2) == 0) bus.data_mbe   = BW'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
